// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared IF-stage types and constants
package if_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  localparam addr_t       RESET_PC  = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;
  localparam word_t       NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    HOLD   = 2'd1,
    BRANCH = 2'd2,
    JUMP   = 2'd3
  } npc_sel_e;

  // Redirect targets are always word aligned in the PC.
  function automatic addr_t align_word(input addr_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with valid bit and fetch counter
module if_id_reg
  import if_pkg::*;
#(
  parameter word_t NOP_WORD = if_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        kill,
  input  logic [31:0] ins_in,
  input  logic [31:0] pc_plus4,
  output logic [31:0] if_id_ins,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  // kill beats stall so a redirect or flush always leaves a bubble behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_ins      <= NOP_WORD;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
      fetch_count    <= 32'h0;
    end else if (kill) begin
      if_id_ins      <= NOP_WORD;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
    end else if (!stall) begin
      if_id_ins      <= ins_in;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
      fetch_count    <= fetch_count + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - program counter, next-PC select and IF/ID capture
module if_fetch_unit
  import if_pkg::*;
#(
  parameter addr_t       RESET_PC  = if_pkg::RESET_PC,
  parameter int unsigned PC_STEP   = if_pkg::PC_STEP,
  parameter word_t       NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] ins_in,
  output logic [31:0] ins_address,
  output logic [31:0] if_id_ins,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  addr_t    pc;
  addr_t    pc_plus4;
  npc_sel_e npc_sel;
  logic     redirect;
  logic     kill;

  assign pc_plus4    = pc + addr_t'(PC_STEP);
  assign redirect    = jump | branch_taken;
  assign kill        = redirect | flush;
  assign ins_address = pc;

  always_comb begin
    npc_sel = SEQ;
    if (jump)              npc_sel = JUMP;
    else if (branch_taken) npc_sel = BRANCH;
    else if (stall)        npc_sel = HOLD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      case (npc_sel)
        JUMP:    pc <= align_word(jump_target);
        BRANCH:  pc <= align_word(branch_target);
        HOLD:    pc <= pc;
        default: pc <= pc_plus4;
      endcase
    end
  end

  if_id_reg #(
    .NOP_WORD(NOP_INSTR)
  ) u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .kill          (kill),
    .ins_in        (ins_in),
    .pc_plus4      (pc_plus4),
    .if_id_ins     (if_id_ins),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] ins_in;
  logic [31:0] ins_address;
  logic [31:0] if_id_ins;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // Reference state, kept as plain integers/words.
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic [31:0] m_pp4;
  logic        m_valid;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h3441_0001;
    if (a == 32'h4) return 32'h0063_1002;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign ins_in = mem_word(ins_address);

  if_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .ins_in        (ins_in),
    .ins_address   (ins_address),
    .if_id_ins     (if_id_ins),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".addr"},  ins_address,          m_pc);
    check_eq({tag, ".ins"},   if_id_ins,            m_ins);
    check_eq({tag, ".pp4"},   if_id_pc_plus4,       m_pp4);
    check_eq({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
    check_eq({tag, ".count"}, fetch_count,          m_count);
  endtask

  // Drive one cycle of controls, advance the reference, then compare after the edge.
  task automatic step(input string tag, input logic rst, input logic st, input logic fl,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    logic [31:0] next_pc;
    reset = rst; stall = st; flush = fl;
    branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt;
    if (rst) begin
      next_pc = 32'h0;
      m_ins = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
    end else begin
      if (jp)      next_pc = jt & 32'hFFFF_FFFC;
      else if (br) next_pc = bt & 32'hFFFF_FFFC;
      else if (st) next_pc = m_pc;
      else         next_pc = m_pc + 32'd4;
      if (jp || br || fl) begin
        m_ins = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      end else if (!st) begin
        m_ins = mem_word(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
        m_count = m_count + 32'd1;
      end
    end
    m_pc = next_pc;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    m_pc = 32'h0; m_ins = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;

    step("reset", 1, 0, 0, 0, 0, 0, 0);
    step("run0",  0, 0, 0, 0, 0, 0, 0);
    check_eq("first_word", if_id_ins, 32'h3441_0001);
    step("run1",  0, 0, 0, 0, 0, 0, 0);
    check_eq("second_word", if_id_ins, 32'h0063_1002);
    check_eq("pc_is_8", ins_address, 32'h8);

    for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 0, 0, 0, 0);
    step("unstall", 0, 0, 0, 0, 0, 0, 0);
    check_eq("pc_is_12", ins_address, 32'hC);
    step("to16", 0, 0, 0, 0, 0, 0, 0);

    step("branch", 0, 0, 0, 1, 32'h0000_0026, 0, 0);
    check_eq("branch_pc", ins_address, 32'h24);
    step("after_br", 0, 0, 0, 0, 0, 0, 0);
    check_eq("after_br_pp4", if_id_pc_plus4, 32'h28);

    step("jmp_br_stall", 0, 1, 0, 1, 32'h80, 1, 32'h40);
    check_eq("jump_wins", ins_address, 32'h40);

    step("jmp12", 0, 0, 0, 0, 0, 1, 32'hC);
    step("run12", 0, 1, 0, 0, 0, 0, 0);
    step("flush_stall", 0, 1, 1, 0, 0, 0, 0);
    check_eq("flush_pc_held", ins_address, 32'hC);

    step("jmp_top", 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    step("wrap",    0, 0, 0, 0, 0, 0, 0);
    check_eq("wrap_pc", ins_address, 32'h0);
    check_eq("wrap_pp4", if_id_pc_plus4, 32'h0);
    step("run_w",   0, 0, 0, 0, 0, 0, 0);
    step("stall_w", 0, 1, 0, 0, 0, 0, 0);
    step("rst_mid", 1, 1, 0, 1, 32'h100, 1, 32'h200);
    check_eq("rst_count", fetch_count, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom_range(0, 99);
      step("rand",
           (r < 2),
           ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 10), $urandom(),
           ($urandom_range(0, 99) < 7),  $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
